// File: rtl/multi_policy_replacement_controller_pkg.sv
// replacement_pkg: shared definitions for the multi-policy replacement
// controller: policy encodings, LFSR tap mask and default seed, and a
// compile-time log2 helper used to size way indices.
package replacement_pkg;

  typedef enum logic [1:0] {
    POLICY_LRU    = 2'b00,
    POLICY_PLRU   = 2'b01,
    POLICY_FIFO   = 2'b10,
    POLICY_RANDOM = 2'b11
  } policy_e;

  // Fibonacci taps 16,14,13,11 as a mask over lfsr[15:0] (shift-left form).
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  function automatic int unsigned log2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/multi_policy_replacement_controller_plru_tree.sv
// plru_tree: combinational tree pseudo-LRU logic for one set.
// Ports:
//   bits      - current node bits of the set, heap order (node 0 = root)
//   access    - way being accessed
//   next_bits - node bits after the access (path points away from access)
//   victim    - way reached by walking the tree (0 = lower half, 1 = upper)
module plru_tree
  import replacement_pkg::*;
#(
  parameter int unsigned NUMBER_OF_WAYS = 4
) (
  input  logic [NUMBER_OF_WAYS-2:0]        bits,
  input  logic [log2(NUMBER_OF_WAYS)-1:0]  access,
  output logic [NUMBER_OF_WAYS-2:0]        next_bits,
  output logic [log2(NUMBER_OF_WAYS)-1:0]  victim
);

  localparam int unsigned W = log2(NUMBER_OF_WAYS);

  int unsigned upd_node;
  int unsigned vic_node;
  logic        dir;
  logic        node_bit;

  // Node selection is done by compare-per-node so no variable-width index
  // is applied to the small node vector.
  always_comb begin
    next_bits = bits;
    upd_node  = 0;
    dir       = 1'b0;
    for (int unsigned l = 0; l < W; l++) begin
      dir = access[W-1-l];
      for (int unsigned n = 0; n < NUMBER_OF_WAYS - 1; n++) begin
        if (n == upd_node) next_bits[n] = ~dir;
      end
      upd_node = 2 * upd_node + 1 + (dir ? 1 : 0);
    end
  end

  always_comb begin
    vic_node = 0;
    node_bit = 1'b0;
    for (int unsigned l = 0; l < W; l++) begin
      node_bit = 1'b0;
      for (int unsigned n = 0; n < NUMBER_OF_WAYS - 1; n++) begin
        if (n == vic_node) node_bit = bits[n];
      end
      vic_node = 2 * vic_node + 1 + (node_bit ? 1 : 0);
    end
    victim = W'(vic_node - (NUMBER_OF_WAYS - 1));
  end

endmodule

// File: rtl/multi_policy_replacement_controller.sv
// multi_policy_replacement_controller: per-set victim selector supporting
// true LRU, tree PLRU, FIFO and LFSR-random replacement. All policy state
// for the addressed set is updated on every valid access so the policy
// select may change at any time.
// Ports:
//   clock, reset               - clock, synchronous active-high reset
//   ways_in_use                - valid bits of the addressed set
//   current_index              - set addressed this cycle
//   replacement_policy_select  - 00 LRU, 01 PLRU, 10 FIFO, 11 random
//   current_access             - way hit or filled this cycle
//   access_valid, access_fill  - access strobe and miss-fill qualifier
//   report                     - trace request; no effect on outputs
//   selected_way               - one-hot victim for current_index
module multi_policy_replacement_controller
  import replacement_pkg::*;
#(
  parameter int unsigned NUMBER_OF_WAYS = 4,
  parameter int unsigned INDEX_BITS     = 8,
  parameter logic [15:0] LFSR_SEED      = LFSR_DEFAULT_SEED
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUMBER_OF_WAYS-1:0]       ways_in_use,
  input  logic [INDEX_BITS-1:0]           current_index,
  input  logic [1:0]                      replacement_policy_select,
  input  logic [log2(NUMBER_OF_WAYS)-1:0] current_access,
  input  logic                            access_valid,
  input  logic                            access_fill,
  input  logic                            report,
  output logic [NUMBER_OF_WAYS-1:0]       selected_way
);

  localparam int unsigned W    = log2(NUMBER_OF_WAYS);
  localparam int unsigned SETS = 2 ** INDEX_BITS;

  logic [W-1:0]                lru_age   [SETS][NUMBER_OF_WAYS];
  logic [NUMBER_OF_WAYS-2:0]   plru_bits [SETS];
  logic [W-1:0]                fifo_ptr  [SETS];
  logic [15:0]                 lfsr;

  logic [W-1:0]                lru_next  [NUMBER_OF_WAYS];
  logic [W-1:0]                lru_victim;
  logic [W-1:0]                acc_age;
  logic [NUMBER_OF_WAYS-2:0]   plru_next;
  logic [W-1:0]                plru_victim;
  logic                        has_free;
  logic [W-1:0]                free_way;
  logic [W-1:0]                victim_way;
  policy_e                     policy;

  // report has no effect on the datapath.
  logic report_unused;
  assign report_unused = report;

  assign policy = policy_e'(replacement_policy_select);

  plru_tree #(.NUMBER_OF_WAYS(NUMBER_OF_WAYS)) u_plru (
    .bits      (plru_bits[current_index]),
    .access    (current_access),
    .next_bits (plru_next),
    .victim    (plru_victim)
  );

  always_comb begin
    acc_age    = lru_age[current_index][current_access];
    lru_victim = '0;
    for (int unsigned i = 0; i < NUMBER_OF_WAYS; i++) begin
      if (lru_age[current_index][i] == W'(NUMBER_OF_WAYS - 1)) lru_victim = W'(i);
      if (W'(i) == current_access)
        lru_next[i] = '0;
      else if (lru_age[current_index][i] < acc_age)
        lru_next[i] = lru_age[current_index][i] + W'(1);
      else
        lru_next[i] = lru_age[current_index][i];
    end
  end

  // Downward scan so the lowest-numbered unused way wins.
  always_comb begin
    has_free = 1'b0;
    free_way = '0;
    for (int unsigned i = NUMBER_OF_WAYS; i > 0; i--) begin
      if (!ways_in_use[i-1]) begin
        has_free = 1'b1;
        free_way = W'(i - 1);
      end
    end
  end

  always_comb begin
    victim_way = '0;
    if (has_free) begin
      victim_way = free_way;
    end else begin
      unique case (policy)
        POLICY_LRU:    victim_way = lru_victim;
        POLICY_PLRU:   victim_way = plru_victim;
        POLICY_FIFO:   victim_way = fifo_ptr[current_index];
        POLICY_RANDOM: victim_way = lfsr[W-1:0];
        default:       victim_way = '0;
      endcase
    end
    selected_way             = '0;
    selected_way[victim_way] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        for (int unsigned i = 0; i < NUMBER_OF_WAYS; i++) begin
          lru_age[s][i] <= W'(NUMBER_OF_WAYS - 1 - i);
        end
        plru_bits[s] <= '0;
        fifo_ptr[s]  <= '0;
      end
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
      if (access_valid) begin
        for (int unsigned i = 0; i < NUMBER_OF_WAYS; i++) begin
          lru_age[current_index][i] <= lru_next[i];
        end
        plru_bits[current_index] <= plru_next;
        if (access_fill && (current_access == fifo_ptr[current_index]))
          fifo_ptr[current_index] <= fifo_ptr[current_index] + W'(1);
      end
    end
  end

endmodule
